peripheral_arbiter: RTL and testbench

PERIPHERAL_ARBITER -- requirements
Module: peripheral_arbiter

---
 rtl/periph_arb_pkg.sv | 23 ++
 rtl/peripheral_arbiter_watchdog.sv | 51 +++++
 rtl/peripheral_arbiter.sv | 171 +++++++++++++++++
 tb/tb_peripheral_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/periph_arb_pkg.sv
// ---------------------------------------------------------------------------
// periph_arb_pkg
//   Shared definitions for the two-master peripheral arbiter:
//     arb_state_t     - arbiter FSM states (IDLE, GRANT_A, GRANT_B)
//     MASTER_A/B      - encoding of the last_served bit
//     WATCHDOG_LIMIT  - consecutive locked cycles before a forced hand-over
//                       (only used when PERIPH_ARB_WATCHDOG_EN is defined)
// ---------------------------------------------------------------------------
package periph_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    localparam logic MASTER_A = 1'b0;
    localparam logic MASTER_B = 1'b1;

    localparam int WATCHDOG_LIMIT = 16;
    localparam int WATCHDOG_WIDTH = $clog2(WATCHDOG_LIMIT);

endpackage

// File: rtl/peripheral_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// peripheral_arbiter_watchdog
//   Counts consecutive cycles in which the granted master holds its grant by
//   lock. On the WATCHDOG_LIMIT-th such cycle, if the other master is
//   requesting, force_switch is raised so the arbiter hands the grant over
//   regardless of lock; the count then restarts from zero.
//
// Ports
//   clock         in   system clock
//   reset_n       in   asynchronous active-low reset
//   locked        in   granted master has lock & req this cycle
//   other_req     in   the non-granted master is requesting
//   force_switch  out  override lock and grant the other master next edge
// ---------------------------------------------------------------------------
module peripheral_arbiter_watchdog
    import periph_arb_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic locked,
    input  logic other_req,
    output logic force_switch
);

    logic [WATCHDOG_WIDTH-1:0] count;
    logic [WATCHDOG_WIDTH-1:0] count_next;
    logic                      expired;

    // count holds the index of the current locked cycle, so the limit-th
    // cycle is the one where count equals LIMIT-1.
    assign expired      = (count == WATCHDOG_WIDTH'(WATCHDOG_LIMIT - 1));
    assign force_switch = locked & other_req & expired;

    always_comb begin
        count_next = '0;
        if (locked && !force_switch) begin
            // Saturate while nobody else wants the bus, so the hand-over
            // happens as soon as the other master shows up.
            count_next = expired ? count : count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/peripheral_arbiter.sv
// ---------------------------------------------------------------------------
// peripheral_arbiter
//   Two-master arbiter in front of a peripheral register block. Ties from
//   IDLE go to the master not served last; a granted master may keep the bus
//   with lock. Acks and the write strobe are combinational from the grant
//   state and the granted master's req, so an asynchronous reset drops them
//   in the same cycle.
//
//   Optional: define PERIPH_ARB_WATCHDOG_EN to bound how long a locked
//   master can starve the other one (WATCHDOG_LIMIT cycles).
//
// Ports
//   clock, reset_n                  system clock, async active-low reset
//   a_req/b_req                     access request, held until ack
//   a_lock/b_lock                   keep the grant after this access
//   a_address/b_address [31:0]      master address
//   a_data/b_data       [31:0]      master write data
//   a_write/b_write                 1 = write, 0 = read
//   a_ack/b_ack                     access completes this cycle
//   a_rdata/b_rdata     [31:0]      read data, valid with the matching ack
//   periph_address/periph_data      muxed address / write data to peripheral
//   periph_write                    write strobe (captured on negedge)
//   periph_rdata        [31:0]      combinational read data from peripheral
// ---------------------------------------------------------------------------
module peripheral_arbiter
    import periph_arb_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_req,
    input  logic        a_lock,
    input  logic [31:0] a_address,
    input  logic [31:0] a_data,
    input  logic        a_write,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_lock,
    input  logic [31:0] b_address,
    input  logic [31:0] b_data,
    input  logic        b_write,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic [31:0] periph_address,
    output logic [31:0] periph_data,
    output logic        periph_write,
    input  logic [31:0] periph_rdata
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_served;
    logic       last_served_next;
    logic       wd_force;

`ifdef PERIPH_ARB_WATCHDOG_EN
    logic grant_locked;
    logic other_req;

    assign grant_locked = ((state == GRANT_A) && a_lock && a_req) ||
                          ((state == GRANT_B) && b_lock && b_req);
    assign other_req    = ((state == GRANT_A) && b_req) ||
                          ((state == GRANT_B) && a_req);

    peripheral_arbiter_watchdog u_watchdog (
        .clock        (clock),
        .reset_n      (reset_n),
        .locked       (grant_locked),
        .other_req    (other_req),
        .force_switch (wd_force)
    );
`else
    assign wd_force = 1'b0;
`endif

    // Next-state logic.
    // NOTE: every signal assigned in an always_comb gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        last_served_next = last_served;

        unique case (state)
            IDLE: begin
                if (a_req && b_req) begin
                    state_next = (last_served == MASTER_A) ? GRANT_B : GRANT_A;
                end else if (a_req) begin
                    state_next = GRANT_A;
                end else if (b_req) begin
                    state_next = GRANT_B;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT_A: begin
                if (a_lock && a_req && !wd_force) begin
                    state_next = GRANT_A;
                end else if (b_req) begin
                    state_next = GRANT_B;
                end else if (a_req) begin
                    state_next = GRANT_A;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT_B: begin
                if (b_lock && b_req && !wd_force) begin
                    state_next = GRANT_B;
                end else if (a_req) begin
                    state_next = GRANT_A;
                end else if (b_req) begin
                    state_next = GRANT_B;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Re-marking on a stay is harmless: last_served already names the
        // granted master while it holds the bus.
        if (state_next == GRANT_A) begin
            last_served_next = MASTER_A;
        end else if (state_next == GRANT_B) begin
            last_served_next = MASTER_B;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_served <= MASTER_B;   // A wins the first tie after reset
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
        end
    end

    // Output mux: purely a function of the current grant and the granted
    // master's inputs, so it never waits for a clock edge.
    always_comb begin
        periph_address = '0;
        periph_data    = '0;
        periph_write   = 1'b0;
        a_ack          = 1'b0;
        a_rdata        = '0;
        b_ack          = 1'b0;
        b_rdata        = '0;

        unique case (state)
            GRANT_A: begin
                periph_address = a_address;
                periph_data    = a_data;
                periph_write   = a_write & a_req;
                a_ack          = a_req;
                a_rdata        = periph_rdata;
            end
            GRANT_B: begin
                periph_address = b_address;
                periph_data    = b_data;
                periph_write   = b_write & b_req;
                b_ack          = b_req;
                b_rdata        = periph_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_peripheral_arbiter.sv
// ---------------------------------------------------------------------------
// tb_peripheral_arbiter
//   Directed bench for peripheral_arbiter. Inputs change 2 time units after
//   a posedge; outputs are sampled at that point (away from the edge).
//   Lock expectations follow PERIPH_ARB_WATCHDOG_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_peripheral_arbiter;

    logic        clock;
    logic        reset_n;
    logic        a_req, a_lock, a_write;
    logic [31:0] a_address, a_data;
    logic        b_req, b_lock, b_write;
    logic [31:0] b_address, b_data;
    logic        a_ack, b_ack;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] periph_address, periph_data, periph_rdata;
    logic        periph_write;

    int tests_run    = 0;
    int tests_failed = 0;

    peripheral_arbiter dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .a_req          (a_req),
        .a_lock         (a_lock),
        .a_address      (a_address),
        .a_data         (a_data),
        .a_write        (a_write),
        .a_ack          (a_ack),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_lock         (b_lock),
        .b_address      (b_address),
        .b_data         (b_data),
        .b_write        (b_write),
        .b_ack          (b_ack),
        .b_rdata        (b_rdata),
        .periph_address (periph_address),
        .periph_data    (periph_data),
        .periph_write   (periph_write),
        .periph_rdata   (periph_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"},    periph_address, 32'h0);
        check({tag, "_data"},    periph_data,    32'h0);
        check({tag, "_write"},   32'(periph_write), 32'h0);
        check({tag, "_a_ack"},   32'(a_ack),     32'h0);
        check({tag, "_b_ack"},   32'(b_ack),     32'h0);
        check({tag, "_a_rdata"}, a_rdata,        32'h0);
        check({tag, "_b_rdata"}, b_rdata,        32'h0);
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    logic exp_a;

    initial begin
        reset_n      = 1'b0;
        a_req        = 1'b0; a_lock = 1'b0; a_write = 1'b0;
        a_address    = '0;   a_data = '0;
        b_req        = 1'b0; b_lock = 1'b0; b_write = 1'b0;
        b_address    = '0;   b_data = '0;
        periph_rdata = 32'h5555_AAAA;

        // Reset holds IDLE even with requests present.
        #2;
        a_req = 1'b1; b_req = 1'b1;
        tick;
        check_idle("reset");
        a_req = 1'b0; b_req = 1'b0;
        reset_n = 1'b1;
        tick;
        check_idle("post_reset");

        // Single write by A.
        a_req = 1'b1; a_write = 1'b1; a_address = 32'd2; a_data = 32'd1;
        #1;
        check("wr_no_ack_in_idle", 32'(a_ack), 32'h0);
        tick;
        check("wr_a_ack",   32'(a_ack),        32'h1);
        check("wr_b_ack",   32'(b_ack),        32'h0);
        check("wr_write",   32'(periph_write), 32'h1);
        check("wr_addr",    periph_address,    32'd2);
        check("wr_data",    periph_data,       32'd1);
        a_req = 1'b0;
        #1;
        check("drop_req_ack",   32'(a_ack),        32'h0);
        check("drop_req_write", 32'(periph_write), 32'h0);
        tick;
        check_idle("wr_done");
        a_write = 1'b0;

        // Reset after A was served: A still wins the first tie.
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        a_address = 32'h0000_00A0; b_address = 32'h0000_00B0;
        a_data    = 32'h1111_0000; b_data    = 32'h2222_0000;
        a_req = 1'b1; b_req = 1'b1;
        tick;
        check("tie_a_ack", 32'(a_ack), 32'h1);
        check("tie_b_ack", 32'(b_ack), 32'h0);
        check("tie_addr",  periph_address, 32'h0000_00A0);
        a_req = 1'b0;
        tick;
        check("tie2_b_ack", 32'(b_ack), 32'h1);
        check("tie2_a_ack", 32'(a_ack), 32'h0);
        check("tie2_addr",  periph_address, 32'h0000_00B0);
        check("tie2_data",  periph_data,    32'h2222_0000);

        // Both held high: grant alternates with no idle cycle.
        a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("alt_a_ack", 32'(a_ack), (i % 2 == 0) ? 32'h1 : 32'h0);
            check("alt_b_ack", 32'(b_ack), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        a_req = 1'b0; b_req = 1'b0;
        tick;
        check_idle("alt_done");

        // Read by B.
        b_req = 1'b1; b_write = 1'b0; periph_rdata = 32'd1;
        tick;
        check("rd_b_ack",   32'(b_ack),        32'h1);
        check("rd_b_rdata", b_rdata,           32'd1);
        check("rd_a_rdata", a_rdata,           32'h0);
        check("rd_write",   32'(periph_write), 32'h0);
        periph_rdata = 32'hDEAD_BEEF;
        #1;
        check("rd_b_rdata2", b_rdata, 32'hDEAD_BEEF);
        b_req = 1'b0;
        tick;
        check_idle("rd_done");

        // Lock: A holds the bus while B waits.
        a_req = 1'b1; a_lock = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
`ifdef PERIPH_ARB_WATCHDOG_EN
            exp_a = (i != 16);
`else
            exp_a = 1'b1;
`endif
            check($sformatf("lock_a_ack_%0d", i), 32'(a_ack), 32'(exp_a));
            check($sformatf("lock_b_ack_%0d", i), 32'(b_ack), 32'(!exp_a));
        end
        a_lock = 1'b0;
        tick;
        check("unlock_b_ack", 32'(b_ack), 32'h1);
        check("unlock_a_ack", 32'(a_ack), 32'h0);
        a_req = 1'b0; b_req = 1'b0;
        tick;
        check_idle("lock_done");

        // Lock without req releases the grant.
        a_req = 1'b1; a_lock = 1'b1; a_address = 32'h0000_0C0C;
        tick;
        check("lnr_a_ack", 32'(a_ack), 32'h1);
        a_req = 1'b0;
        tick;
        check_idle("lnr_released");
        a_lock = 1'b0;

        // Reset mid-grant drops write strobe and ack at once.
        b_req = 1'b1; b_write = 1'b1;
        tick;
        check("rst_b_ack_before", 32'(b_ack),        32'h1);
        check("rst_write_before", 32'(periph_write), 32'h1);
        reset_n = 1'b0;
        #1;
        check("rst_b_ack_async", 32'(b_ack),        32'h0);
        check("rst_write_async", 32'(periph_write), 32'h0);
        check("rst_addr_async",  periph_address,    32'h0);
        reset_n = 1'b1;
        b_write = 1'b0;
        a_req = 1'b1;
        tick;
        check("rst_tie_a_ack", 32'(a_ack), 32'h1);
        check("rst_tie_b_ack", 32'(b_ack), 32'h0);
        a_req = 1'b0; b_req = 1'b0;
        tick;
        tick;
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
